multdiv_unit: RTL and testbench



---
 rtl/multdiv_unit.sv | 155 +++++++++++++++
 tb/tb_multdiv_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 shift-add) / divide (restoring) unit, one shared accumulator.
// Define MULTDIV_DIV_EN to build the divider; otherwise a divide request completes at once with an exception.
module multdiv_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_operandA,
  input  logic [DATA_WIDTH-1:0] data_operandB,
  input  logic                  ctrl_MULT,
  input  logic                  ctrl_DIV,
  output logic [DATA_WIDTH-1:0] data_result,
  output logic                  data_exception,
  output logic                  data_resultRDY,
  output logic                  data_busy
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [2*W+1:0]  acc;
  logic [W:0]      opnd;
  logic            sign;
  logic            op_div;

  logic [W:0]      in_mag_a;
  logic [W:0]      in_mag_b;
  logic [W:0]      low_src;
  logic [W+1:0]    mul_sum;
  logic [2*W+1:0]  mul_next;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    res_fix;
  logic            exc_fix;

`ifdef MULTDIV_DIV_EN
  logic            div_zero;
  logic            div_ovf;
  logic [W+1:0]    div_hi;
  logic [W+2:0]    div_diff;
  logic [2*W+1:0]  div_next;
  logic [W-1:0]    quot;
`endif

  // Magnitudes are one bit wider so the most-negative operand needs no special case.
  always_comb begin
    in_mag_a = data_operandA[W-1] ? ({1'b0, ~data_operandA} + {{W{1'b0}}, 1'b1})
                                  : {1'b0, data_operandA};
    in_mag_b = data_operandB[W-1] ? ({1'b0, ~data_operandB} + {{W{1'b0}}, 1'b1})
                                  : {1'b0, data_operandB};
    low_src  = ctrl_MULT ? in_mag_b : in_mag_a;
  end

  // Accumulator: high W+2 bits hold partial product / remainder, low W bits multiplier / quotient.
  always_comb begin
    mul_sum  = acc[2*W+1:W] + (acc[0] ? {1'b0, opnd} : {(W+2){1'b0}});
    mul_next = {1'b0, mul_sum, acc[W-1:1]};
  end

`ifdef MULTDIV_DIV_EN
  always_comb begin
    div_hi   = acc[2*W:W-1];
    div_diff = {1'b0, div_hi} - {2'b00, opnd};
    div_next = div_diff[W+2] ? {div_hi, acc[W-2:0], 1'b0}
                             : {div_diff[W+1:0], acc[W-2:0], 1'b1};
  end
`endif

  always_comb begin
    prod    = sign ? -acc[2*W-1:0] : acc[2*W-1:0];
    res_fix = prod[W-1:0];
    exc_fix = prod[2*W-1:W] != {W{prod[W-1]}};
`ifdef MULTDIV_DIV_EN
    quot = sign ? -acc[W-1:0] : acc[W-1:0];
    if (op_div) begin
      if (div_zero) begin
        res_fix = '0;
        exc_fix = 1'b1;
      end else if (div_ovf) begin
        res_fix = {1'b1, {(W-1){1'b0}}};
        exc_fix = 1'b1;
      end else begin
        res_fix = quot;
        exc_fix = 1'b0;
      end
    end
`else
    if (op_div) begin
      res_fix = '0;
      exc_fix = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      acc            <= '0;
      opnd           <= '0;
      sign           <= 1'b0;
      op_div         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      data_busy      <= 1'b0;
`ifdef MULTDIV_DIV_EN
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_MULT || ctrl_DIV) begin
            op_div    <= !ctrl_MULT;
            sign      <= data_operandA[W-1] ^ data_operandB[W-1];
            opnd      <= ctrl_MULT ? in_mag_a : in_mag_b;
            acc       <= {{(W+1){1'b0}}, low_src};
            count     <= '0;
            data_busy <= 1'b1;
`ifdef MULTDIV_DIV_EN
            div_zero  <= data_operandB == '0;
            div_ovf   <= (data_operandA == {1'b1, {(W-1){1'b0}}}) && (data_operandB == '1);
            state     <= RUN;
`else
            state     <= ctrl_MULT ? RUN : FIX;
`endif
          end
        end
        RUN: begin
`ifdef MULTDIV_DIV_EN
          acc <= op_div ? div_next : mul_next;
`else
          acc <= mul_next;
`endif
          count <= count + CW'(1);
          if (count == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          data_result    <= res_fix;
          data_exception <= exc_fix;
          data_resultRDY <= 1'b1;
          data_busy      <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and random checks of multdiv_unit against an arithmetic reference model.
module tb_multdiv_unit;

`ifdef MULTDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        data_busy;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_res = '0;
  logic        last_exc = 1'b0;

  multdiv_unit #(.DATA_WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic exc);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      p   = sa * sb;
      res = p[31:0];
      exc = (p < -(longint'(1) << 31)) || (p >= (longint'(1) << 31));
    end else if (!DIV_EN) begin
      res = 32'h0;
      exc = 1'b1;
    end else if (sb == 0) begin
      res = 32'h0;
      exc = 1'b1;
    end else if (sa == -(longint'(1) << 31) && sb == -1) begin
      res = 32'h8000_0000;
      exc = 1'b1;
    end else begin
      p   = sa / sb;
      res = p[31:0];
      exc = 1'b0;
    end
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_res"},  data_result, 32'h0);
    check({tag, "_exc"},  data_exception, 1'b0);
    check({tag, "_rdy"},  data_resultRDY, 1'b0);
    check({tag, "_busy"}, data_busy, 1'b0);
  endtask

  // inject >= 0 pulses ctrl_DIV that many cycles into the run to confirm it is ignored.
  task automatic run_op(input bit do_mult, input bit do_div, input logic [31:0] a,
                        input logic [31:0] b, input int inject);
    logic [31:0] exp_res;
    logic        exp_exc;
    int          cycles;
    int          exp_lat;
    bit          as_div;
    as_div  = !do_mult;
    model(as_div, a, b, exp_res, exp_exc);
    exp_lat = (as_div && !DIV_EN) ? 1 : 33;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = do_mult;
    ctrl_DIV      = do_div;
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    check("rdy_after_start", data_resultRDY, 1'b0);
    cycles = 0;
    while (data_resultRDY !== 1'b1 && cycles < 60) begin
      check("busy_in_flight", data_busy, 1'b1);
      check("result_held", data_result, last_res);
      check("exception_held", data_exception, last_exc);
      if (cycles == inject) ctrl_DIV = 1'b1;
      @(posedge clock); #1;
      ctrl_DIV = 1'b0;
      cycles++;
    end
    check("latency", cycles, exp_lat);
    check("result", data_result, exp_res);
    check("exception", data_exception, exp_exc);
    check("busy_done", data_busy, 1'b0);
    last_res = exp_res;
    last_exc = exp_exc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, miscompares %0d", miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    int          kind;
    bit          rst_div;

    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("reset_state");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check_idle_outputs("after_release");

    run_op(1'b1, 1'b0, 32'd7,          32'hFFFF_FFFA, -1);
    run_op(1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, -1);
    run_op(1'b1, 1'b0, 32'h8000_0000,  32'd1,         -1);
    run_op(1'b1, 1'b0, 32'h8000_0000,  32'h8000_0000, -1);
    run_op(1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,         -1);
    run_op(1'b0, 1'b1, 32'd5,          32'd0,         -1);
    run_op(1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, -1);
    run_op(1'b0, 1'b1, 32'h8000_0000,  32'd1,         -1);
    run_op(1'b1, 1'b0, 32'd3,          32'd4,         10);
    run_op(1'b1, 1'b1, 32'd5,          32'hFFFF_FFFA, -1);

    // Reset mid-operation: no completion pulse, outputs cleared immediately.
    rst_div = DIV_EN;
    @(negedge clock);
    data_operandA = 32'd1000;
    data_operandB = 32'd10;
    ctrl_MULT     = !rst_div;
    ctrl_DIV      = rst_div;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    repeat (14) begin
      @(posedge clock); #1;
      check("no_rdy_before_reset", data_resultRDY, 1'b0);
    end
    reset = 1'b0;
    #1;
    check_idle_outputs("reset_mid_op");
    repeat (3) begin
      @(posedge clock); #1;
      check_idle_outputs("held_in_reset");
    end
    @(negedge clock);
    reset    = 1'b1;
    last_res = '0;
    last_exc = 1'b0;
    @(posedge clock); #1;
    check_idle_outputs("after_mid_reset");
    run_op(1'b1, 1'b0, 32'd2, 32'd3, -1);

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 3);
      ra   = $urandom;
      rb   = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = {{16{ra[15]}}, ra[15:0]}; rb = {{16{rb[15]}}, rb[15:0]}; end
        3: rb = {{24{rb[7]}}, rb[7:0]};
        default: ;
      endcase
      run_op(kind < 2, kind != 0, ra, rb, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
